pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer, flush, and control-bubble insertion. It replaces fixed-field stage registers between ID/EX, EX/MEM and MEM/WB, so back-pressure from a stalled later stage no longer requires a combinational stall path back to the hazard unit. Control and data fields are carried as flat buses; the bubble value and widths are parameters.

---
 rtl/pipe_stage_buf.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : pipe_stage_buf                                             |
// | Brief    : Pipeline-stage register with valid/ready handshake, a      |
// |            one-entry skid buffer, flush and control-bubble insertion. |
// |            Every output is driven by a flop.                          |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module pipe_stage_buf #(
  parameter int                 CTRL_W      = 12,
  parameter int                 DATA_W      = 128,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bubble,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       bubble_cnt
);

  // EMPTY: nothing held; ONE: main entry full; TWO: main and skid full
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  state_t              r_state,     w_state_nxt;
  logic [CTRL_W-1:0]   r_main_ctrl, w_main_ctrl_nxt;
  logic [DATA_W-1:0]   r_main_data, w_main_data_nxt;
  logic [CTRL_W-1:0]   r_skid_ctrl, w_skid_ctrl_nxt;
  logic [DATA_W-1:0]   r_skid_data, w_skid_data_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [15:0]         r_bubble_cnt, w_bubble_cnt_nxt;

  logic                w_accept;
  logic                w_pop;
  logic [CTRL_W-1:0]   w_in_ctrl_eff;

  // Handshake qualifiers; flush discards the incoming beat
  assign w_accept      = in_valid & r_in_ready & ~flush;
  assign w_pop         = r_out_valid & out_ready;
  // A load-use bubble keeps the beat valid but neutralises its control
  assign w_in_ctrl_eff = in_bubble ? CTRL_BUBBLE : in_ctrl;

  // Next-state and next-entry contents; flush overrides accept and pop
  always_comb begin
    w_state_nxt      = r_state;
    w_main_ctrl_nxt  = r_main_ctrl;
    w_main_data_nxt  = r_main_data;
    w_skid_ctrl_nxt  = r_skid_ctrl;
    w_skid_data_nxt  = r_skid_data;
    w_bubble_cnt_nxt = r_bubble_cnt;

    if (w_accept && in_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
      w_bubble_cnt_nxt = r_bubble_cnt + 16'd1;
    end

    if (flush) begin
      w_state_nxt     = S_EMPTY;
      w_main_ctrl_nxt = CTRL_BUBBLE;
      w_skid_ctrl_nxt = CTRL_BUBBLE;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_main_ctrl_nxt = w_in_ctrl_eff;
            w_main_data_nxt = in_data;
            w_state_nxt     = S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_pop) begin
            w_main_ctrl_nxt = w_in_ctrl_eff;
            w_main_data_nxt = in_data;
          end else if (w_accept) begin
            w_skid_ctrl_nxt = w_in_ctrl_eff;
            w_skid_data_nxt = in_data;
            w_state_nxt     = S_TWO;
          end else if (w_pop) begin
            // Emptied entry carries a harmless control value; data holds
            w_main_ctrl_nxt = CTRL_BUBBLE;
            w_state_nxt     = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
            w_skid_ctrl_nxt = CTRL_BUBBLE;
            w_state_nxt     = S_ONE;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // State, storage and handshake flops; ready/valid are derived from the
  // next state so they are registered rather than combinational from inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_EMPTY;
      r_main_ctrl  <= CTRL_BUBBLE;
      r_main_data  <= '0;
      r_skid_ctrl  <= CTRL_BUBBLE;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_main_ctrl  <= w_main_ctrl_nxt;
      r_main_data  <= w_main_data_nxt;
      r_skid_ctrl  <= w_skid_ctrl_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_in_ready   <= (w_state_nxt != S_TWO);
      r_out_valid  <= (w_state_nxt != S_EMPTY);
      r_bubble_cnt <= w_bubble_cnt_nxt;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_ctrl   = r_main_ctrl;
  assign out_data   = r_main_data;
  assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_pipe_stage_buf                                          |
// | Brief    : Directed self-checking bench for pipe_stage_buf            |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_pipe_stage_buf;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_bubble;
  logic [11:0]  in_ctrl;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [11:0]  out_ctrl;
  logic [127:0] out_data;
  logic [15:0]  bubble_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_buf dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bubble  (in_bubble),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  // Watchdog: the sequence is fully bounded, this only guards against hangs
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge, then sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_bubble = 1'b0;
    in_ctrl   = 12'h000;
    in_data   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; flush = 1'b0; in_bubble = 1'b0;
    in_valid = 1'b1; in_ctrl = 12'hABC; in_data = 128'h99;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_ctrl !== 12'h000) begin errors++; $display("FAIL rst_out_ctrl got=%h exp=000", out_ctrl); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL rst_bubble_cnt got=%h exp=0", bubble_cnt); end
    reset = 1'b0;
    idle_inputs();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_capture got=%0b exp=0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = 12'(i); in_data = 128'(i);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 128'(i)) begin
        errors++; $display("FAIL stream_beat%0d got v=%0b d=%h exp v=1 d=%h", i, out_valid, out_data, 128'(i));
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got=%0b exp=1", i, in_ready); end
    end
    idle_inputs();
    tick();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 12'h000) begin
      errors++; $display("FAIL stream_drain got v=%0b c=%h exp v=0 c=000", out_valid, out_ctrl);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 12'h00A; in_data = 128'hA;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 128'hA) begin
      errors++; $display("FAIL bp_A_appears got v=%0b d=%h exp v=1 d=a", out_valid, out_data);
    end
    out_ready = 1'b0;
    in_ctrl = 12'h00B; in_data = 128'hB;
    tick();
    checks++; if (out_data !== 128'hA || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_skid got d=%h rdy=%0b exp d=a rdy=0", out_data, in_ready);
    end
    in_ctrl = 12'h00C; in_data = 128'hC;
    tick();
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 128'hA || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold got v=%0b d=%h rdy=%0b exp v=1 d=a rdy=0", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 128'hB || out_ctrl !== 12'h00B || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_B got v=%0b d=%h c=%h rdy=%0b exp v=1 d=b c=00b rdy=1", out_valid, out_data, out_ctrl, in_ready);
    end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 128'hC) begin
      errors++; $display("FAIL bp_C got v=%0b d=%h exp v=1 d=c", out_valid, out_data);
    end
    idle_inputs();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 12'h001; in_data = 128'hA1;
    tick();
    in_ctrl = 12'h002; in_data = 128'hA2;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_two got=%0b exp=0", in_ready); end
    flush = 1'b1; in_ctrl = 12'h003; in_data = 128'hA3; in_bubble = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 12'h000) begin
      errors++; $display("FAIL flush_state got v=%0b rdy=%0b c=%h exp v=0 rdy=1 c=000", out_valid, in_ready, out_ctrl);
    end
    checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL flush_cnt got=%h exp=0", bubble_cnt); end
    flush = 1'b0; in_bubble = 1'b0; out_ready = 1'b1;
    in_ctrl = 12'h004; in_data = 128'hA4;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 128'hA4 || out_ctrl !== 12'h004) begin
      errors++; $display("FAIL flush_next got v=%0b d=%h c=%h exp v=1 d=a4 c=004", out_valid, out_data, out_ctrl);
    end
    idle_inputs();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got=%0b exp=0", out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    in_valid = 1'b1; in_bubble = 1'b1; in_ctrl = 12'hFFF; in_data = 128'h55;
    tick();
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 12'h000 || out_data !== 128'h55) begin
      errors++; $display("FAIL bubble_beat got v=%0b c=%h d=%h exp v=1 c=000 d=55", out_valid, out_ctrl, out_data);
    end
    checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL bubble_cnt1 got=%h exp=0001", bubble_cnt); end
    for (int i = 0; i < 65533; i++) tick();
    checks++; if (bubble_cnt !== 16'hFFFE) begin errors++; $display("FAIL bubble_cnt_fffe got=%h exp=fffe", bubble_cnt); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL bubble_sat got=%h exp=ffff", bubble_cnt); end
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bubble_cnt !== 16'hFFFF || out_valid !== 1'b0) begin
      errors++; $display("FAIL bubble_flush_keep got cnt=%h v=%0b exp cnt=ffff v=0", bubble_cnt, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 12'h011; in_data = 128'h11;
    tick();
    in_ctrl = 12'h022; in_data = 128'h22;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_two got=%0b exp=0", in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 12'h000 || out_data !== 128'h0 || bubble_cnt !== 16'h0) begin
      errors++; $display("FAIL mid_reset got v=%0b rdy=%0b c=%h d=%h cnt=%h exp v=0 rdy=1 c=000 d=0 cnt=0",
                         out_valid, in_ready, out_ctrl, out_data, bubble_cnt);
    end
    out_ready = 1'b1;
    in_ctrl = 12'h007; in_data = 128'h7;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 128'h7) begin
      errors++; $display("FAIL mid_push7 got v=%0b d=%h exp v=1 d=7", out_valid, out_data);
    end
    idle_inputs();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_drain got=%0b exp=0", out_valid); end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_bubble();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
